// File: rtl/spine_egress_buffer.sv
// spine_egress_buffer: buffers flits from a valid-only router spine output port and
// presents them to the spine link with a valid/ready handshake. Storage is a
// DEPTH-entry circular buffer feeding one output register; total occupancy never
// exceeds DEPTH. Counts dropped flits and flags a link blocked for STALL_LIMIT cycles.
// Optional feature macro: SPINE_EGRESS_PARITY_EN (even parity check in, parity out).
module spine_egress_buffer #(
    parameter int unsigned DWIDTH      = 16,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned STALL_LIMIT = 64,
    parameter int unsigned ADDR_MSB    = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DWIDTH-1:0]        rtr_in_data,
    input  logic                     rtr_in_valid,
`ifdef SPINE_EGRESS_PARITY_EN
    input  logic                     rtr_in_parity,
    output logic                     spine_out_parity,
`endif
    output logic [DWIDTH-1:0]        spine_out_data,
    output logic                     spine_out_valid,
    input  logic                     spine_out_ready,
    output logic [5:0]               spine_dest_addr,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     fifo_full,
    output logic                     fifo_empty,
    output logic [7:0]               drop_count,
    output logic                     link_stall
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthC    = CntW'(DEPTH);
    localparam logic [7:0]      StallLimC = 8'(STALL_LIMIT);

    typedef enum logic [1:0] {StIdle, StSend, StStalled} state_e;

    state_e              state_q, state_d;
    logic [DWIDTH-1:0]   mem_q [DEPTH];
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]     count_q, count_d;
    logic [DWIDTH-1:0]   out_data_q, out_data_d;
    logic [7:0]          drop_q, drop_d;
    logic [7:0]          stall_q, stall_d;

    logic                out_valid, pop, push, drop, par_ok, load, load_valid, mem_we;
    logic [CntW-1:0]     buf_level;

    assign out_valid = (state_q != StIdle);

    // Datapath: accept/drop decision, output register refill, pointer and count update.
    always_comb begin
        pop        = out_valid && spine_out_ready;
`ifdef SPINE_EGRESS_PARITY_EN
        par_ok     = ((^rtr_in_data) == rtr_in_parity);
`else
        par_ok     = 1'b1;
`endif
        push       = rtr_in_valid && par_ok && ((count_q != DepthC) || pop);
        drop       = rtr_in_valid && !push;
        // Entries held behind the output register.
        buf_level  = count_q - CntW'(out_valid);
        load       = !out_valid || pop;
        load_valid = out_valid && !pop;
        out_data_d = out_data_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        mem_we     = push;
        if (load) begin
            if (buf_level != '0) begin
                out_data_d = mem_q[rd_ptr_q];
                rd_ptr_d   = rd_ptr_q + PtrW'(1);
                load_valid = 1'b1;
            end else if (push) begin
                // Empty bypass: the flit goes straight to the output register.
                out_data_d = rtr_in_data;
                load_valid = 1'b1;
                mem_we     = 1'b0;
            end
        end
        if (mem_we) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        count_d = count_q + CntW'(push) - CntW'(pop);
        drop_d  = (drop && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;
    end

    // Link FSM: idle / sending / stalled, with the blocked-cycle counter.
    always_comb begin
        state_d = state_q;
        stall_d = stall_q;
        case (state_q)
            StIdle: begin
                stall_d = '0;
                if (load_valid) state_d = StSend;
            end
            StSend: begin
                if (pop) begin
                    stall_d = '0;
                    state_d = load_valid ? StSend : StIdle;
                end else begin
                    stall_d = stall_q + 8'd1;
                    if (stall_d == StallLimC) state_d = StStalled;
                end
            end
            StStalled: begin
                if (pop) begin
                    stall_d = '0;
                    state_d = load_valid ? StSend : StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                stall_d = '0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            out_data_q <= '0;
            drop_q     <= '0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            out_data_q <= out_data_d;
            drop_q     <= drop_d;
            stall_q    <= stall_d;
        end
    end

    // Buffer storage write; contents need no reset since pointers gate reads.
    always_ff @(posedge clk) begin
        if (!reset && mem_we) begin
            mem_q[wr_ptr_q] <= rtr_in_data;
        end
    end

`ifdef SPINE_EGRESS_PARITY_EN
    logic par_q, par_d;

    // Even parity of the output flit, registered alongside the data.
    always_comb begin
        par_d = load ? ^out_data_d : par_q;
    end

    // Parity register.
    always_ff @(posedge clk) begin
        if (reset) par_q <= 1'b0;
        else       par_q <= par_d;
    end

    assign spine_out_parity = par_q;
`endif

    assign spine_out_valid = out_valid;
    assign spine_out_data  = out_data_q;
    assign spine_dest_addr = out_data_q[ADDR_MSB -: 6];
    assign fifo_count      = count_q;
    assign fifo_full       = (count_q == DepthC);
    assign fifo_empty      = (count_q == '0);
    assign drop_count      = drop_q;
    assign link_stall      = (state_q == StStalled);

endmodule

// File: tb/tb_spine_egress_buffer.sv
// Testbench for spine_egress_buffer: scoreboard of accepted flits plus a small
// occupancy/drop/stall model, compared against the DUT every cycle.
module tb_spine_egress_buffer;

    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned LIM   = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] rtr_in_data;
    logic          rtr_in_valid;
    logic          rtr_in_parity;
    logic [DW-1:0] spine_out_data;
    logic          spine_out_valid;
    logic          spine_out_ready;
    logic [5:0]    spine_dest_addr;
    logic [3:0]    fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    drop_count;
    logic          link_stall;
`ifdef SPINE_EGRESS_PARITY_EN
    logic          spine_out_parity;
`endif

    always #5 clk = ~clk;

    spine_egress_buffer #(
        .DWIDTH(DW), .DEPTH(DEPTH), .STALL_LIMIT(LIM), .ADDR_MSB(15)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .rtr_in_data     (rtr_in_data),
        .rtr_in_valid    (rtr_in_valid),
`ifdef SPINE_EGRESS_PARITY_EN
        .rtr_in_parity   (rtr_in_parity),
        .spine_out_parity(spine_out_parity),
`endif
        .spine_out_data  (spine_out_data),
        .spine_out_valid (spine_out_valid),
        .spine_out_ready (spine_out_ready),
        .spine_dest_addr (spine_dest_addr),
        .fifo_count      (fifo_count),
        .fifo_full       (fifo_full),
        .fifo_empty      (fifo_empty),
        .drop_count      (drop_count),
        .link_stall      (link_stall)
    );

    int unsigned   total = 0;
    int unsigned   bad   = 0;
    logic [DW-1:0] sb_q[$];
    int            m_cnt  = 0;
    int            m_drop = 0;
    int            m_scnt = 0;
    logic          m_stall = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, check outputs at negedge, advance the model.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic rdy, input logic par);
        logic          pop_m, push_m, ok;
        logic [DW-1:0] head;
        rtr_in_valid    = v;
        rtr_in_data     = d;
        spine_out_ready = rdy;
        rtr_in_parity   = par;
        @(negedge clk);
        check_val("valid", spine_out_valid, (m_cnt != 0));
        check_val("count", fifo_count, m_cnt);
        check_val("full", fifo_full, (m_cnt == DEPTH));
        check_val("empty", fifo_empty, (m_cnt == 0));
        check_val("drops", drop_count, m_drop);
        check_val("stall", link_stall, m_stall);
        if (m_cnt != 0) begin
            head = sb_q[0];
            check_val("data", spine_out_data, head);
            check_val("dest", spine_dest_addr, head[15:10]);
`ifdef SPINE_EGRESS_PARITY_EN
            check_val("parity", spine_out_parity, ^head);
`endif
        end
        ok = 1'b1;
`ifdef SPINE_EGRESS_PARITY_EN
        ok = ((^d) == par);
`endif
        pop_m  = (m_cnt != 0) && rdy;
        push_m = v && ok && ((m_cnt < DEPTH) || pop_m);
        if (pop_m) void'(sb_q.pop_front());
        if (push_m) sb_q.push_back(d);
        else if (v && m_drop < 255) m_drop++;
        if (pop_m || m_cnt == 0) begin
            m_scnt  = 0;
            m_stall = 1'b0;
        end else if (!m_stall) begin
            m_scnt++;
            if (m_scnt == LIM) m_stall = 1'b1;
        end
        m_cnt = m_cnt + int'(push_m) - int'(pop_m);
        @(posedge clk);
        #1;
    endtask

    // Synchronous reset with a flit presented that must be ignored.
    task automatic do_reset();
        reset           = 1'b1;
        rtr_in_valid    = 1'b1;
        rtr_in_data     = 16'hBEEF;
        rtr_in_parity   = ^rtr_in_data;
        spine_out_ready = 1'b1;
        @(posedge clk);
        #1;
        reset        = 1'b0;
        rtr_in_valid = 1'b0;
        sb_q.delete();
        m_cnt   = 0;
        m_drop  = 0;
        m_scnt  = 0;
        m_stall = 1'b0;
        check_val("rst_valid", spine_out_valid, 1'b0);
        check_val("rst_count", fifo_count, 0);
        check_val("rst_drops", drop_count, 0);
        check_val("rst_data", spine_out_data, 0);
        check_val("rst_dest", spine_dest_addr, 0);
        check_val("rst_empty", fifo_empty, 1'b1);
    endtask

    initial begin
        reset           = 1'b1;
        rtr_in_valid    = 1'b0;
        rtr_in_data     = '0;
        rtr_in_parity   = 1'b0;
        spine_out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Single flit through the empty bypass.
        step(1'b1, 16'h0C01, 1'b1, 1'b0);
        check_val("tp1_dest", spine_dest_addr, 6'h03);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        step(1'b0, 16'h0, 1'b1, 1'b0);

        // Overflow: ten flits into an eight-deep buffer, then drain.
        for (int i = 1; i <= 10; i++) step(1'b1, 16'(i), 1'b0, ^16'(i));
        check_val("tp2_drops", drop_count, 2);
        for (int i = 0; i < 10; i++) step(1'b0, 16'h0, 1'b1, 1'b0);

        // Full buffer streaming with simultaneous push and pop.
        for (int i = 0; i < 8; i++) step(1'b1, 16'(16'h4100 + i), 1'b0, ^16'(16'h4100 + i));
        for (int i = 0; i < 20; i++) step(1'b1, 16'(16'h8200 + i), 1'b1, ^16'(16'h8200 + i));
        check_val("tp3_full", fifo_full, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, 16'h0, 1'b1, 1'b0);

        // Stall detection on a single blocked flit.
        step(1'b1, 16'hFC55, 1'b0, ^16'hFC55);
        for (int i = 0; i < 70; i++) step(1'b0, 16'h0, 1'b0, 1'b0);
        check_val("tp4_stall", link_stall, 1'b1);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        check_val("tp4_release", link_stall, 1'b0);
        step(1'b0, 16'h0, 1'b1, 1'b0);

        // Reset with flits buffered.
        for (int i = 0; i < 5; i++) step(1'b1, 16'(16'h3300 + i), 1'b0, ^16'(16'h3300 + i));
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b1, 1'b0);

`ifdef SPINE_EGRESS_PARITY_EN
        // Bad parity is dropped; good parity passes with parity out.
        step(1'b1, 16'h0003, 1'b1, 1'b1);
        check_val("tp6_drop", drop_count, 1);
        step(1'b1, 16'h0003, 1'b1, 1'b0);
        check_val("tp6_par", spine_out_parity, 1'b0);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        step(1'b0, 16'h0, 1'b1, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spine_egress_buffer.md
Name: spine_egress_buffer

Overview:
- Sits directly downstream of one router spine output port (spineXY_out_data/spineXY_out_valid). That port is valid-only, with no backpressure.
- Buffers the router's flits in a FIFO and presents them to the spine link with a valid/ready handshake.
- Drives the 6-bit destination address that the next router's spine_dest_addr input expects.
- Counts dropped flits and flags a stalled link. One instance per spine port, four per group.

Parameters:
DWIDTH, 16, flit width; must match router DWIDTH
DEPTH, 8, FIFO entries; power of two, minimum 2
STALL_LIMIT, 64, consecutive blocked cycles before link_stall asserts; range 1..255
ADDR_MSB, 15, MSB of the destination field in the flit; field is [ADDR_MSB:ADDR_MSB-5]

Ports:
clk  in  1  system clock (the ACLK domain)
reset  in  1  synchronous, active-high reset
rtr_in_data  in  DWIDTH  flit from the router spine output
rtr_in_valid  in  1  flit qualifier; no ready is returned
spine_out_data  out  DWIDTH  flit toward the spine link
spine_out_valid  out  1  output flit valid
spine_out_ready  in  1  spine link accepts the flit when high together with valid
spine_dest_addr  out  6  equals spine_out_data[ADDR_MSB:ADDR_MSB-5]
fifo_count  out  $clog2(DEPTH)+1  occupancy; includes the output register
fifo_full  out  1  fifo_count == DEPTH
fifo_empty  out  1  fifo_count == 0
drop_count  out  8  saturating count of rejected flits
link_stall  out  1  stall-limit flag

Behaviour:
- Reset: one clock and one reset. Reset is synchronous and active-high. Reset behaviour is sampled on the rising edge of clk while reset=1. After reset:
  - spine_out_valid=0, spine_out_data=0, spine_dest_addr=0
  - fifo_count=0, fifo_empty=1, fifo_full=0
  - drop_count=0, link_stall=0
  - FSM in IDLE, stall counter=0
- Reset mid-operation discards all buffered flits. Flits arriving during reset are ignored and not counted.
- Storage:
  - DEPTH-1 RAM/register entries plus one output register. Total capacity is DEPTH.
  - Pointers wrap modulo DEPTH-1 entries. Alternatively, use a DEPTH-entry circular buffer that also feeds the output register; occupancy semantics are identical either way.
- Push: occurs when rtr_in_valid=1 and (fifo_count<DEPTH or a pop happens in the same cycle).
  - Full and no pop: the flit is dropped and drop_count increments. drop_count saturates at 255.
  - Simultaneous push and pop when full: the push is accepted and fifo_count is unchanged.
- Pop: occurs when spine_out_valid && spine_out_ready.
- Output register:
  - Loads the FIFO head after a pop, or when empty.
  - Empty bypass: a flit pushed in cycle N while fifo_count==0 appears with spine_out_valid=1 in cycle N+1. Latency is 1 cycle.
  - Back-to-back flits with ready held high stream at 1 flit/cycle with no bubbles.
- Output stability: while spine_out_valid=1 and spine_out_ready=0, spine_out_data and spine_dest_addr hold stable.
- spine_dest_addr: registered together with spine_out_data, so it is always consistent with it.
- FSM, transitions evaluated each clk:
  - IDLE: output register empty, spine_out_valid=0.
    - To SEND when a flit is loaded.
  - SEND: spine_out_valid=1.
    - Pop with nothing buffered and no push: to IDLE.
    - Pop with a next flit available (buffered or being pushed): stay in SEND.
    - ready=0: stall counter increments. When the counter reaches STALL_LIMIT, go to STALLED.
  - STALLED: spine_out_valid=1, link_stall=1.
    - On a pop, clear the stall counter and deassert link_stall in the next cycle.
    - After the pop, go to SEND if a flit remains, otherwise to IDLE.
    - Pushes and drops continue as normal in this state.
- Stall counter: 8 bits. It resets to 0 on every pop and in IDLE.
- Flags: fifo_full, fifo_empty and fifo_count are registered and updated in the same cycle as the push/pop.

Optional Feature:
- Macro: SPINE_EGRESS_PARITY_EN.
- Defined:
  - Adds output port spine_out_parity (1 bit) = ^spine_out_data, even parity, registered with the data.
  - Adds input rtr_in_parity (1 bit).
  - A flit whose even-parity check fails on arrival is dropped and counted in drop_count, same as an overflow drop.
  - Reset value of spine_out_parity is 0.
- Not defined: neither port exists and no parity check is performed.

Test Plan:
- Reset, then push 0x0C01 in cycle 1 with ready=1 -> spine_out_valid=1 in cycle 2 with data 0x0C01, dest_addr 6'h03; spine_out_valid=0 in cycle 3; fifo_empty=1.
- ready=0; push 10 flits 0x0001..0x000A at DEPTH=8 -> fifo_full=1 after the 8th; drop_count=2; on release, outputs 0x0001..0x0008 in order at 1/cycle.
- Full FIFO and ready=1, push every cycle for 20 cycles -> fifo_count stays 8; drop_count stays 0; output is in order.
- ready=0 for 70 cycles with one flit, STALL_LIMIT=64 -> link_stall rises 64 cycles after valid; data stays stable; on ready=1, pop occurs and link_stall=0 the next cycle.
- Reset asserted with 5 flits buffered -> next cycle spine_out_valid=0, fifo_count=0, drop_count=0; a flit presented during reset is not output.
- With SPINE_EGRESS_PARITY_EN: push 0x0003 with rtr_in_parity=1 -> dropped, drop_count=1; push 0x0003 with parity 0 -> output with spine_out_parity=0.
